// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package rvx10p_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of pipeline WB, long-unit, decode and register-file port signals.
interface wb_port_arbiter_if;
  import rvx10p_wb_pkg::*;

  logic                  RegWriteW;
  logic [REG_ADDR_W-1:0] RdW;
  logic [XLEN-1:0]       ResultW;
  logic                  LongValid;
  logic [REG_ADDR_W-1:0] LongRd;
  logic [XLEN-1:0]       LongResult;
  logic                  LongReady;
  logic                  IssueLong;
  logic [REG_ADDR_W-1:0] IssueRd;
  logic [REG_ADDR_W-1:0] Rs1D;
  logic [REG_ADDR_W-1:0] Rs2D;
  logic [REG_ADDR_W-1:0] RdD;
  logic                  BusyStallD;
  logic                  StallPipe;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WriteRd;
  logic [XLEN-1:0]       WriteData;

  modport master (
    output RegWriteW, RdW, ResultW, LongValid, LongRd, LongResult,
           IssueLong, IssueRd, Rs1D, Rs2D, RdD,
    input  LongReady, BusyStallD, StallPipe, RegWrite, WriteRd, WriteData
  );

  modport slave (
    input  RegWriteW, RdW, ResultW, LongValid, LongRd, LongResult,
           IssueLong, IssueRd, Rs1D, Rs2D, RdD,
    output LongReady, BusyStallD, StallPipe, RegWrite, WriteRd, WriteData
  );

endinterface

// File: rtl/wb_pending_fifo.sv
// Small FIFO holding long-unit results until an idle write-port slot appears.
module wb_pending_fifo
  import rvx10p_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_push,
  input  logic      i_pop,
  input  wb_entry_t i_data,
  output wb_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  wb_entry_t   r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_push;
  logic        w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline WB and buffered long-unit
// results, with a busy scoreboard for Decode and a starvation bubble request.
module wb_port_arbiter
  import rvx10p_wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  wb_port_arbiter_if.slave  bus
);

  localparam int unsigned     CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0]       r_count;
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;
  logic                w_pipe_own;
  logic                w_head_write;
  logic                w_push;
  logic                w_full;
  logic                w_empty;
  wb_entry_t           w_head;
  wb_entry_t           w_in;

  assign w_pipe_own   = bus.RegWriteW && (bus.RdW != '0);
  assign w_head_write = !w_empty && !w_pipe_own;
  assign w_push       = bus.LongValid && !w_full && (bus.LongRd != '0);
  assign w_in.rd      = bus.LongRd;
  assign w_in.data    = bus.LongResult;

  wb_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_head_write),
    .i_data  (w_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    bus.RegWrite  = 1'b0;
    bus.WriteRd   = '0;
    bus.WriteData = '0;
    if (w_pipe_own) begin
      bus.RegWrite  = 1'b1;
      bus.WriteRd   = bus.RdW;
      bus.WriteData = bus.ResultW;
    end else if (!w_empty) begin
      bus.RegWrite  = 1'b1;
      bus.WriteRd   = w_head.rd;
      bus.WriteData = w_head.data;
    end
  end

  // Set is applied after clear so a same-register collision leaves the bit busy.
  always_comb begin
    w_busy_next = r_busy;
    if (w_head_write) w_busy_next[w_head.rd] = 1'b0;
    if (bus.IssueLong && (bus.IssueRd != '0)) w_busy_next[bus.IssueRd] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_next;
  end

  always_ff @(posedge clk) begin
    if (reset || w_empty || w_head_write) r_count <= '0;
    else if (r_count != LIMIT_C)          r_count <= r_count + 1'b1;
  end

  assign bus.LongReady  = !w_full;
  assign bus.StallPipe  = (r_count == LIMIT_C);
  assign bus.BusyStallD = r_busy[bus.Rs1D] | r_busy[bus.Rs2D] | r_busy[bus.RdD];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench: expected write-port transactions go to a queue checked by a monitor.
module tb_wb_port_arbiter;
  import rvx10p_wb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  wb_entry_t   exp_q[$];
  wb_entry_t   mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.RegWrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", bus.WriteRd, bus.WriteData);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_rd", 32'(bus.WriteRd), 32'(mon_e.rd));
          chk("write_data", bus.WriteData, mon_e.data);
        end
      end else begin
        chk("idle_rd", 32'(bus.WriteRd), 32'd0);
        chk("idle_data", bus.WriteData, 32'd0);
      end
    end
  end

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    wb_entry_t t;
    t.rd   = rd;
    t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
    bus.RegWriteW = 1'b1;
    bus.RdW       = rd;
    bus.ResultW   = d;
    if (rd != 5'd0) expect_wr(rd, d);
  endtask

  task automatic long_res(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.LongValid  = v;
    bus.LongRd     = rd;
    bus.LongResult = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.IssueLong = 1'b1;
    bus.IssueRd   = rd;
  endtask

  // Advance one cycle; single-cycle pulses are cleared for the new cycle.
  task automatic nxt();
    @(posedge clk);
    #1;
    bus.RegWriteW = 1'b0;
    bus.RdW       = '0;
    bus.ResultW   = '0;
    bus.IssueLong = 1'b0;
    bus.IssueRd   = '0;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic decode(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    bus.Rs1D = r1;
    bus.Rs2D = r2;
    bus.RdD  = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.RegWriteW = 1'b0; bus.RdW = '0; bus.ResultW = '0;
    bus.IssueLong = 1'b0; bus.IssueRd = '0;
    long_res(1'b0, 5'd0, 32'd0);
    decode(5'd0, 5'd0, 5'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    decode(5'd5, 5'd7, 5'd9);
    smp();
    chk("reset_longready", 32'(bus.LongReady), 32'd1);
    chk("reset_stallpipe", 32'(bus.StallPipe), 32'd0);
    chk("reset_busystall", 32'(bus.BusyStallD), 32'd0);
    nxt(); decode(5'd0, 5'd0, 5'd0); pipe(5'd3, 32'h0000_1234); smp();
    nxt(); bus.RegWriteW = 1'b1; bus.RdW = 5'd0; bus.ResultW = 32'h0000_ABCD; smp();

    // Single long result rd=5
    nxt(); issue(5'd5); smp();
    chk("busy5_not_yet", 32'(bus.BusyStallD), 32'd0);
    nxt(); long_res(1'b1, 5'd5, 32'hDEAD_BEEF); decode(5'd5, 5'd0, 5'd0); smp();
    chk("long5_ready", 32'(bus.LongReady), 32'd1);
    chk("busy5_set", 32'(bus.BusyStallD), 32'd1);
    nxt(); long_res(1'b0, 5'd0, 32'd0); expect_wr(5'd5, 32'hDEAD_BEEF); smp();
    chk("busy5_during_write", 32'(bus.BusyStallD), 32'd1);
    nxt(); smp();
    chk("busy5_cleared", 32'(bus.BusyStallD), 32'd0);
    decode(5'd0, 5'd0, 5'd0);

    // RAW/WAW stall on rd=7, write deferred behind pipeline WB
    nxt(); issue(5'd7); smp();
    nxt(); decode(5'd7, 5'd0, 5'd0); smp();
    chk("busy7_rs1", 32'(bus.BusyStallD), 32'd1);
    nxt(); decode(5'd0, 5'd0, 5'd7); smp();
    chk("busy7_rdd", 32'(bus.BusyStallD), 32'd1);
    nxt(); decode(5'd0, 5'd7, 5'd0); smp();
    chk("busy7_rs2", 32'(bus.BusyStallD), 32'd1);
    nxt(); decode(5'd0, 5'd0, 5'd7); long_res(1'b1, 5'd7, 32'h7777_7777); pipe(5'd1, 32'h0000_0011); smp();
    nxt(); long_res(1'b0, 5'd0, 32'd0); expect_wr(5'd7, 32'h7777_7777); smp();
    chk("busy7_until_write", 32'(bus.BusyStallD), 32'd1);
    nxt(); smp();
    chk("busy7_cleared", 32'(bus.BusyStallD), 32'd0);
    decode(5'd0, 5'd0, 5'd0);

    // Starvation: WB busy every cycle, FIFO fills, bubble drains it
    nxt(); pipe(5'd1, 32'h101); long_res(1'b1, 5'd10, 32'hA0A0_A0A0); smp();
    chk("starve_ready0", 32'(bus.LongReady), 32'd1);
    nxt(); pipe(5'd2, 32'h102); long_res(1'b1, 5'd11, 32'hB0B0_B0B0); smp();
    chk("starve_ready1", 32'(bus.LongReady), 32'd1);
    nxt(); pipe(5'd3, 32'h103); long_res(1'b1, 5'd12, 32'hC0C0_C0C0); smp();
    chk("full_ready", 32'(bus.LongReady), 32'd0);
    chk("stall_c1", 32'(bus.StallPipe), 32'd0);
    nxt(); pipe(5'd4, 32'h104); smp();
    chk("stall_c2", 32'(bus.StallPipe), 32'd0);
    nxt(); pipe(5'd5, 32'h105); smp();
    chk("stall_c3", 32'(bus.StallPipe), 32'd0);
    nxt(); pipe(5'd6, 32'h106); smp();
    chk("stall_at_limit", 32'(bus.StallPipe), 32'd1);
    nxt(); expect_wr(5'd10, 32'hA0A0_A0A0); smp();
    chk("stall_bubble", 32'(bus.StallPipe), 32'd1);
    chk("full_pop_ready", 32'(bus.LongReady), 32'd0);
    nxt(); expect_wr(5'd11, 32'hB0B0_B0B0); smp();
    chk("stall_released", 32'(bus.StallPipe), 32'd0);
    chk("ready_after_pop", 32'(bus.LongReady), 32'd1);
    nxt(); long_res(1'b0, 5'd0, 32'd0); expect_wr(5'd12, 32'hC0C0_C0C0); smp();
    chk("held_result_ready", 32'(bus.LongReady), 32'd1);
    nxt(); smp();

    // rd=0 result is accepted and discarded
    nxt(); long_res(1'b1, 5'd0, 32'h0000_0055); smp();
    chk("rd0_ready", 32'(bus.LongReady), 32'd1);
    nxt(); long_res(1'b0, 5'd0, 32'd0); smp();
    nxt(); smp();
    chk("rd0_no_stall", 32'(bus.StallPipe), 32'd0);

    // Same-cycle set and clear on rd=9: set wins
    nxt(); issue(5'd9); smp();
    nxt(); long_res(1'b1, 5'd9, 32'h0000_0009); smp();
    nxt(); long_res(1'b0, 5'd0, 32'd0); expect_wr(5'd9, 32'h0000_0009); issue(5'd9); smp();
    nxt(); decode(5'd0, 5'd0, 5'd9); smp();
    chk("busy9_set_wins", 32'(bus.BusyStallD), 32'd1);
    nxt(); long_res(1'b1, 5'd9, 32'h0000_0099); smp();
    chk("busy9_held", 32'(bus.BusyStallD), 32'd1);
    nxt(); long_res(1'b0, 5'd0, 32'd0); expect_wr(5'd9, 32'h0000_0099); smp();
    chk("busy9_during_write", 32'(bus.BusyStallD), 32'd1);
    nxt(); smp();
    chk("busy9_cleared", 32'(bus.BusyStallD), 32'd0);
    decode(5'd0, 5'd0, 5'd0);

    // Reset with two buffered entries and busy bits set
    nxt(); issue(5'd20); pipe(5'd1, 32'h201); smp();
    nxt(); issue(5'd21); pipe(5'd1, 32'h202); long_res(1'b1, 5'd20, 32'h0000_0020); smp();
    nxt(); pipe(5'd1, 32'h203); long_res(1'b1, 5'd21, 32'h0000_0021); smp();
    nxt(); pipe(5'd1, 32'h204); long_res(1'b0, 5'd0, 32'd0); decode(5'd20, 5'd21, 5'd0); smp();
    chk("pre_reset_full", 32'(bus.LongReady), 32'd0);
    chk("pre_reset_busy", 32'(bus.BusyStallD), 32'd1);
    nxt(); reset = 1'b1; smp();
    nxt(); reset = 1'b0; smp();
    chk("post_reset_ready", 32'(bus.LongReady), 32'd1);
    chk("post_reset_busy", 32'(bus.BusyStallD), 32'd0);
    chk("post_reset_stall", 32'(bus.StallPipe), 32'd0);
    nxt(); smp();
    chk("exp_queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
